// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks rd/regwrite/memread
// of in-flight instructions and produces forward selects, load-use stall and flush controls.
module hazard_forward_ctrl #(
    parameter int REG_BITS = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Hold,
    input  logic [REG_BITS-1:0] ID_Rs1,
    input  logic [REG_BITS-1:0] ID_Rs2,
    input  logic                ID_UseRs1,
    input  logic                ID_UseRs2,
    input  logic [REG_BITS-1:0] ID_Rd,
    input  logic                ID_RegWrite,
    input  logic                ID_MemRead,
    input  logic                EX_BranchTaken,
    output logic [1:0]          ForwardA,
    output logic [1:0]          ForwardB,
    output logic                Stall,
    output logic                Flush_IF_ID,
    output logic                Flush_ID_EX,
    output logic [CNT_W-1:0]    StallCount
);

    // The W stage never produces a select (the register file bypasses WB->ID itself),
    // and M's memread is never consulted, so only the fields that feed a decision are kept.
    logic [REG_BITS-1:0] eRd_q, mRd_q;
    logic                eRegWrite_q, eMemRead_q, mRegWrite_q;
    logic [1:0]          forwardA_q, forwardB_q, forwardA_d, forwardB_d;
    logic [CNT_W-1:0]    stallCount_q, stallCount_d;
    logic                loadUse;

    function automatic logic [1:0] selectFor(
        input logic [REG_BITS-1:0] rs,
        input logic                flush,
        input logic                eRw,
        input logic [REG_BITS-1:0] eRd,
        input logic                mRw,
        input logic [REG_BITS-1:0] mRd
    );
        if (flush)                       return 2'b00;
        else if (rs == '0)               return 2'b11;
        else if (eRw && (eRd == rs))     return 2'b01;
        else if (mRw && (mRd == rs))     return 2'b10;
        else                             return 2'b00;
    endfunction

    always_comb begin
        loadUse = eMemRead_q && (eRd_q != '0) &&
                  ((ID_UseRs1 && (ID_Rs1 == eRd_q)) || (ID_UseRs2 && (ID_Rs2 == eRd_q)));
    end

    // A taken branch squashes the stalled ID instruction, so it overrides the stall.
    assign Stall       = loadUse & ~EX_BranchTaken;
    assign Flush_IF_ID = EX_BranchTaken;
    assign Flush_ID_EX = EX_BranchTaken | Stall;

    always_comb begin
        forwardA_d   = selectFor(ID_Rs1, Flush_ID_EX, eRegWrite_q, eRd_q, mRegWrite_q, mRd_q);
        forwardB_d   = selectFor(ID_Rs2, Flush_ID_EX, eRegWrite_q, eRd_q, mRegWrite_q, mRd_q);
        stallCount_d = stallCount_q;
        if (Stall && (stallCount_q != {CNT_W{1'b1}})) begin
            stallCount_d = stallCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eRd_q        <= '0;
            eRegWrite_q  <= 1'b0;
            eMemRead_q   <= 1'b0;
            mRd_q        <= '0;
            mRegWrite_q  <= 1'b0;
            forwardA_q   <= 2'b00;
            forwardB_q   <= 2'b00;
            stallCount_q <= '0;
        end else if (!Hold) begin
            mRd_q        <= eRd_q;
            mRegWrite_q  <= eRegWrite_q;
            forwardA_q   <= forwardA_d;
            forwardB_q   <= forwardB_d;
            stallCount_q <= stallCount_d;
            if (Flush_ID_EX) begin
                eRd_q       <= '0;
                eRegWrite_q <= 1'b0;
                eMemRead_q  <= 1'b0;
            end else begin
                eRd_q       <= ID_Rd;
                eRegWrite_q <= ID_RegWrite;
                eMemRead_q  <= ID_MemRead;
            end
        end
    end

    assign ForwardA   = forwardA_q;
    assign ForwardB   = forwardB_q;
    assign StallCount = stallCount_q;

endmodule
